branch_ctrl: RTL and testbench

Branch resolution controller for the CPU execute stage. It accepts one branch or jump per handshake and drives the unsigned-select input of the shared branch comparator from the instruction's funct3. It samples the comparator's equal and less-than flags, decides taken/not-taken, and sequences the PC redirect plus a fixed-length pipeline flush. It also keeps saturating statistics counters for resolved and taken branches.

---
 rtl/cpu_branch_pkg.sv | 23 ++
 rtl/branch_decide.sv | 38 +++
 rtl/branch_ctrl.sv | 175 +++++++++++++++++
 tb/tb_branch_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_branch_pkg.sv
// Shared definitions for the branch resolution controller.
//   - RISC-V conditional-branch funct3 encodings
//   - controller state enum
//   - default width of the statistics counters
package cpu_branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPARE,
    S_REDIRECT,
    S_FLUSH
  } state_e;

endpackage

// File: rtl/branch_decide.sv
// Combinational taken/not-taken decision for one branch or jump.
// Ports:
//   funct3_i  - branch funct3 (ignored for jumps)
//   jump_i    - unconditional jump, always taken
//   beq_i     - comparator equal flag
//   blt_i     - comparator less-than flag (signedness chosen upstream)
//   taken_o   - branch is taken
//   illegal_o - funct3 is 010/011 on a conditional branch
module branch_decide
  import cpu_branch_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       jump_i,
  input  logic       beq_i,
  input  logic       blt_i,
  output logic       taken_o,
  output logic       illegal_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would infer a latch.
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    if (jump_i) begin
      taken_o = 1'b1;
    end else begin
      case (funct3_i)
        F3_BEQ:           taken_o = beq_i;
        F3_BNE:           taken_o = !beq_i;
        F3_BLT, F3_BLTU:  taken_o = blt_i;
        F3_BGE, F3_BGEU:  taken_o = !blt_i;
        default:          illegal_o = 1'b1;  // 010/011 have no branch meaning
      endcase
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution controller for the execute stage.
// Accepts one branch/jump per handshake, steers the shared comparator's
// unsigned select, resolves taken/not-taken, then issues a one-cycle PC
// redirect followed by FLUSH_CYCLES cycles of pipeline flush.
// Ports:
//   req_valid/req_ready           - request handshake
//   req_funct3/req_jump/req_target - branch descriptor
//   cmp_BrUn                      - comparator unsigned select (COMPARE only)
//   cmp_BEQ/cmp_BLT               - comparator flags, sampled end of COMPARE
//   redirect_valid/redirect_pc    - PC redirect strobe and registered address
//   flush/stall                   - pipeline control
//   illegal/misalign              - one-cycle error strobes
//   cnt_clear                     - synchronous clear of statistics
//   resolved_cnt/taken_cnt        - saturating statistics counters
module branch_ctrl
  import cpu_branch_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic             req_jump,
  input  logic [XLEN-1:0]  req_target,
  output logic             cmp_BrUn,
  input  logic             cmp_BEQ,
  input  logic             cmp_BLT,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  output logic             stall,
  output logic             illegal,
  output logic             misalign,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] resolved_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  // Flush counter holds 0..FLUSH_CYCLES-1; keep at least one bit so the
  // FLUSH_CYCLES=0 build still elaborates (the FLUSH state is then unused).
  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FLUSH_LOAD =
    (FLUSH_CYCLES > 0) ? FC_W'(FLUSH_CYCLES - 1) : '0;

  state_e            state_q;
  logic [2:0]        funct3_q;
  logic              jump_q;
  logic [XLEN-1:0]   target_q;
  logic [FC_W-1:0]   flush_cnt_q;
  logic              redirect_valid_q;
  logic [XLEN-1:0]   redirect_pc_q;
  logic              illegal_q;
  logic              misalign_q;
  logic [CNT_W-1:0]  resolved_q, resolved_d;
  logic [CNT_W-1:0]  taken_q, taken_d;

  logic dec_taken;
  logic dec_illegal;
  logic resolving;
  logic redirect_go;
  logic misalign_go;

  branch_decide u_decide (
    .funct3_i  (funct3_q),
    .jump_i    (jump_q),
    .beq_i     (cmp_BEQ),
    .blt_i     (cmp_BLT),
    .taken_o   (dec_taken),
    .illegal_o (dec_illegal)
  );

  assign resolving   = (state_q == S_COMPARE);
  // Illegal encodings never report taken, so they need no extra masking.
  assign redirect_go = resolving && dec_taken && !target_q[1];
  assign misalign_go = resolving && dec_taken &&  target_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      funct3_q         <= '0;
      jump_q           <= 1'b0;
      target_q         <= '0;
      flush_cnt_q      <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      illegal_q        <= 1'b0;
      misalign_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // pre-edge values regardless of statement order.
      redirect_valid_q <= 1'b0;
      illegal_q        <= 1'b0;
      misalign_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            funct3_q <= req_funct3;
            jump_q   <= req_jump;
            // Bit 0 is never part of a redirect address; drop it at capture.
            target_q <= {req_target[XLEN-1:1], 1'b0};
            state_q  <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          illegal_q  <= dec_illegal;
          misalign_q <= misalign_go;
          if (redirect_go) begin
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= target_q;
            state_q          <= S_REDIRECT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_REDIRECT: begin
          if (FLUSH_CYCLES == 0) begin
            state_q <= S_IDLE;
          end else begin
            flush_cnt_q <= FLUSH_LOAD;
            state_q     <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (flush_cnt_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            flush_cnt_q <= flush_cnt_q - FC_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Statistics: clear wins over increment; both saturate at all-ones.
  always_comb begin
    resolved_d = resolved_q;
    taken_d    = taken_q;
    if (cnt_clear) begin
      resolved_d = '0;
      taken_d    = '0;
    end else if (resolving) begin
      if (resolved_q != '1) resolved_d = resolved_q + CNT_W'(1);
      if (redirect_go && (taken_q != '1)) taken_d = taken_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resolved_q <= '0;
      taken_q    <= '0;
    end else begin
      resolved_q <= resolved_d;
      taken_q    <= taken_d;
    end
  end

  // State decodes; all derive from registers, so they are glitch-free and
  // take their reset values asynchronously with the state register.
  assign req_ready      = (state_q == S_IDLE);
  assign stall          = (state_q != S_IDLE);
  assign flush          = (state_q == S_FLUSH);
  assign cmp_BrUn       = resolving && funct3_q[1];
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign illegal        = illegal_q;
  assign misalign       = misalign_q;
  assign resolved_cnt   = resolved_q;
  assign taken_cnt      = taken_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: the driver pushes the expected outcome
// of every request into a scoreboard queue; an independent monitor follows
// the DUT cycle by cycle and pops/compares when a request is accepted.
module tb_branch_ctrl;

  localparam int XLEN = 32;
  localparam int FC   = 2;
  localparam int CW   = 5;  // narrow counters so saturation is reachable
  localparam int CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [2:0]      req_funct3 = '0;
  logic            req_jump = 1'b0;
  logic [XLEN-1:0] req_target = '0;
  logic            cmp_BrUn;
  logic            cmp_BEQ;
  logic            cmp_BLT;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic            stall;
  logic            illegal;
  logic            misalign;
  logic            cnt_clear = 1'b0;
  logic [CW-1:0]   resolved_cnt;
  logic [CW-1:0]   taken_cnt;

  // Comparator model: operands held by the driver, signedness from the DUT.
  logic [XLEN-1:0] op1 = '0;
  logic [XLEN-1:0] op2 = '0;
  assign cmp_BEQ = (op1 == op2);
  assign cmp_BLT = cmp_BrUn ? (op1 < op2) : ($signed(op1) < $signed(op2));

  branch_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_funct3     (req_funct3),
    .req_jump       (req_jump),
    .req_target     (req_target),
    .cmp_BrUn       (cmp_BrUn),
    .cmp_BEQ        (cmp_BEQ),
    .cmp_BLT        (cmp_BLT),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .stall          (stall),
    .illegal        (illegal),
    .misalign       (misalign),
    .cnt_clear      (cnt_clear),
    .resolved_cnt   (resolved_cnt),
    .taken_cnt      (taken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            brun;
    logic            redirect;
    logic            illegal;
    logic            misalign;
    logic [XLEN-1:0] pc;
    int              res;
    int              tak;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   m_res  = 0;
  int   m_tak  = 0;
  logic [XLEN-1:0] last_pc = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: RISC-V branch semantics applied directly to the operands.
  function automatic exp_t model(input logic [2:0] f3, input logic jump,
                                 input logic [XLEN-1:0] tgt, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b, input logic clr);
    exp_t e;
    logic taken;
    e.illegal = !jump && (f3 == 3'b010 || f3 == 3'b011);
    if (jump) taken = 1'b1;
    else begin
      case (f3)
        3'b000:  taken = (a == b);
        3'b001:  taken = (a != b);
        3'b100:  taken = ($signed(a) <  $signed(b));
        3'b101:  taken = ($signed(a) >= $signed(b));
        3'b110:  taken = (a <  b);
        3'b111:  taken = (a >= b);
        default: taken = 1'b0;
      endcase
    end
    e.brun     = f3[1];
    e.misalign = taken && tgt[1];
    e.redirect = taken && !tgt[1];
    e.pc       = tgt & ~32'h1;
    if (clr) begin
      m_res = 0;
      m_tak = 0;
    end else begin
      if (m_res < CMAX) m_res++;
      if (e.redirect && m_tak < CMAX) m_tak++;
    end
    e.res = m_res;
    e.tak = m_tak;
    return e;
  endfunction

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 50);
    check("wait_ready", req_ready, 1);
  endtask

  task automatic issue(input logic [2:0] f3, input logic jump, input logic [XLEN-1:0] tgt,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic clr);
    wait_idle();
    @(posedge clk); #1;
    req_funct3 = f3;
    req_jump   = jump;
    req_target = tgt;
    op1        = a;
    op2        = b;
    req_valid  = 1'b1;
    sb.push_back(model(f3, jump, tgt, a, b, clr));
    @(posedge clk); #1;
    req_valid = 1'b0;
    cnt_clear = clr;  // lands in the COMPARE cycle
    @(posedge clk); #1;
    cnt_clear = 1'b0;
  endtask

  // Monitor: independent of the driver, tracks each accepted request.
  initial begin : monitor
    exp_t cur;
    bit   busy = 0;
    int   ph = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 0;
      end else if (!busy) begin
        check("idle_strobes", {redirect_valid, illegal, misalign, flush, stall}, 5'b0);
        check("idle_pc_hold", redirect_pc, last_pc);
        if (req_valid && req_ready) begin
          if (sb.size() == 0) begin
            check("sb_nonempty", 0, 1);
          end else begin
            cur  = sb.pop_front();
            busy = 1;
            ph   = 0;
          end
        end
      end else begin
        ph++;
        if (ph == 1) begin
          check("cmp_brun", cmp_BrUn, cur.brun);
          check("cmp_stall_ready", {stall, req_ready}, 2'b10);
        end else if (ph == 2) begin
          check("illegal", illegal, cur.illegal);
          check("misalign", misalign, cur.misalign);
          check("redirect_valid", redirect_valid, cur.redirect);
          check("resolved_cnt", resolved_cnt, cur.res);
          check("taken_cnt", taken_cnt, cur.tak);
          if (cur.redirect) begin
            check("redirect_pc", redirect_pc, cur.pc);
            check("redirect_stall", {stall, req_ready, flush}, 3'b100);
            last_pc = cur.pc;
          end else begin
            check("ready_after_resolve", {req_ready, stall}, 2'b10);
            busy = 0;
          end
        end else if (ph <= 2 + FC) begin
          check("flush_active", {flush, stall, req_ready, redirect_valid}, 4'b1100);
        end else begin
          check("ready_after_flush", {req_ready, flush, stall}, 3'b100);
          busy = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    int n;
    // Reset state, sampled while reset is still asserted.
    #12;
    check("rst_ready", {req_ready, stall, flush, redirect_valid}, 4'b1000);
    check("rst_cnts", {resolved_cnt, taken_cnt}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed cases.
    issue(3'b000, 1'b0, 32'h100, 32'd5, 32'd5, 1'b0);                 // BEQ taken
    issue(3'b110, 1'b0, 32'h300, 32'hFFFF_FFFF, 32'd1, 1'b0);         // BLTU not taken
    issue(3'b101, 1'b0, 32'h300, 32'hFFFF_FFFF, 32'd1, 1'b0);         // BGE -1 vs 1 not taken
    issue(3'b000, 1'b1, 32'h203, 32'd0, 32'd1, 1'b0);                 // JAL, bit1 set -> misalign
    issue(3'b000, 1'b1, 32'h201, 32'd0, 32'd1, 1'b0);                 // JAL, bit0 cleared
    issue(3'b010, 1'b0, 32'h400, 32'd3, 32'd3, 1'b0);                 // illegal
    issue(3'b011, 1'b0, 32'h400, 32'd3, 32'd4, 1'b0);                 // illegal
    issue(3'b001, 1'b0, 32'h102, 32'd1, 32'd2, 1'b0);                 // BNE taken, misaligned
    issue(3'b111, 1'b0, 32'h500, 32'd7, 32'd7, 1'b0);                 // BGEU taken

    // Saturate both counters, then clear concurrently with a resolution.
    for (int i = 0; i < CMAX + 3; i++) issue(3'b100, 1'b1, 32'h600, 32'd0, 32'd0, 1'b0);
    issue(3'b000, 1'b0, 32'h700, 32'd1, 32'd1, 1'b1);

    // Asynchronous reset in the middle of a flush.
    issue(3'b000, 1'b0, 32'h800, 32'd9, 32'd9, 1'b0);
    n = 0;
    while (!flush && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reached_flush", flush, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ctrl", {flush, stall, req_ready, redirect_valid}, 4'b0010);
    check("async_rst_cnts", {resolved_cnt, taken_cnt}, '0);
    check("async_rst_pc", redirect_pc, 0);
    m_res   = 0;
    m_tak   = 0;
    last_pc = '0;
    sb.delete();
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      logic [2:0]      f3;
      logic            jmp;
      logic [XLEN-1:0] tgt, a, b;
      logic            clr;
      f3  = 3'($urandom_range(0, 7));
      jmp = ($urandom_range(0, 7) == 0);
      tgt = $urandom;
      a   = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a + 32'($urandom_range(0, 2)) - 32'd1;
        2:       b = ~a;
        default: b = $urandom;
      endcase
      clr = ($urandom_range(0, 19) == 0);
      issue(f3, jmp, tgt, a, b, clr);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
